fp_mul_core: RTL and testbench

// Responder end of the stb/ack operand/result handshake used by the FPU wrapper.
// - Accepts two IEEE-754 binary32 operands: A first, then B.
// - Computes A*B with round-to-nearest-even, then returns Z on a held output_z_stb.
// - Multi-cycle, non-pipelined: one operation in flight. Sits under the wrapper as its arithmetic core.

---
 rtl/fp_mul_core.sv | 215 +++++++++++++++++++++
 tb/tb_fp_mul_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_core.sv
// Multi-cycle IEEE-754 binary32 multiplier with stb/ack operand and result channels.
// Round-to-nearest-even; one operation in flight, subnormals normalised one bit per cycle.
module fp_mul_core #(
    parameter int DATA_WIDTH     = 32,
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_a,
    input  logic                  input_a_stb,
    output logic                  input_a_ack,
    input  logic [DATA_WIDTH-1:0] input_b,
    input  logic                  input_b_stb,
    output logic                  input_b_ack,
    output logic [DATA_WIDTH-1:0] output_z,
    output logic                  output_z_stb,
    input  logic                  output_z_ack
);
    // state    | meaning
    // GET_A    | waiting for operand A
    // GET_B    | waiting for operand B
    // UNPACK   | split sign/exponent/significand
    // SPECIAL  | NaN / Inf / zero short-cuts
    // NORM_IN  | left-shift subnormal significands
    // MULT     | significand product and exponent sum
    // NORM_L   | bring product MSB to the top
    // NORM_R   | denormalise results below emin
    // ROUND    | round to nearest even
    // PACK     | assemble result word
    // PUT_Z    | hold result until accepted

    localparam int EW   = EXPONENT_WIDTH + 2;
    localparam int MW   = FRACTION_WIDTH + 1;
    localparam int PW   = 2 * MW;
    localparam int BIAS = 2 ** (EXPONENT_WIDTH - 1) - 1;

    localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] EMAX = EW'(BIAS);
    localparam logic signed [EW-1:0] EINF = EW'(BIAS + 1);

    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, NORM_IN, MULT,
        NORM_L, NORM_R, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0]    a, b;
    logic [MW-1:0]            a_m, b_m, z_m;
    logic signed [EW-1:0]     a_e, b_e, z_e;
    logic                     z_s;
    logic [PW-1:0]            p;
    logic                     sticky;
    logic                     a_ack_d, b_ack_d, z_stb_d;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic round_up;
    logic [MW:0] mant_inc;
    logic [EXPONENT_WIDTH-1:0] pack_field;

    assign a_nan  = (a_e == EINF) && (a_m[FRACTION_WIDTH-1:0] != '0);
    assign b_nan  = (b_e == EINF) && (b_m[FRACTION_WIDTH-1:0] != '0);
    assign a_inf  = (a_e == EINF) && (a_m[FRACTION_WIDTH-1:0] == '0);
    assign b_inf  = (b_e == EINF) && (b_m[FRACTION_WIDTH-1:0] == '0);
    assign a_zero = (a_e == EMIN) && (a_m == '0);
    assign b_zero = (b_e == EMIN) && (b_m == '0);

    assign mant_inc = {1'b0, p[PW-1 -: MW]} + 1'b1;
    assign round_up = p[MW-1] && (p[MW-2] || (|p[MW-3:0]) || sticky || p[MW]);
    assign pack_field = EXPONENT_WIDTH'(z_e + EW'(BIAS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= GET_A;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
        end else begin
            state        <= next_state;
            input_a_ack  <= a_ack_d;
            input_b_ack  <= b_ack_d;
            output_z_stb <= z_stb_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            GET_A:   if (input_a_stb && input_a_ack) next_state = GET_B;
            GET_B:   if (input_b_stb && input_b_ack) next_state = UNPACK;
            UNPACK:  next_state = SPECIAL;
            SPECIAL: begin
                if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero)
                    next_state = PUT_Z;
                else
                    next_state = NORM_IN;
            end
            NORM_IN: if (a_m[MW-1] && b_m[MW-1]) next_state = MULT;
            MULT:    next_state = NORM_L;
            // leave as soon as the shift being applied this cycle lands the MSB
            NORM_L:  if (p[PW-1] || p[PW-2]) next_state = NORM_R;
            NORM_R:  if (z_e >= EMIN) next_state = ROUND;
            ROUND:   next_state = PACK;
            PACK:    next_state = PUT_Z;
            PUT_Z:   if (output_z_stb && output_z_ack) next_state = GET_A;
            default: next_state = GET_A;
        endcase
    end

    always_comb begin
        a_ack_d = (next_state == GET_A);
        b_ack_d = (next_state == GET_B);
        z_stb_d = (next_state == PUT_Z);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            a_m      <= '0;
            b_m      <= '0;
            z_m      <= '0;
            a_e      <= '0;
            b_e      <= '0;
            z_e      <= '0;
            z_s      <= 1'b0;
            p        <= '0;
            sticky   <= 1'b0;
            output_z <= '0;
        end else begin
            case (state)
                GET_A: if (input_a_stb && input_a_ack) a <= input_a;
                GET_B: if (input_b_stb && input_b_ack) b <= input_b;
                UNPACK: begin
                    z_s <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
                    if (a[DATA_WIDTH-2 -: EXPONENT_WIDTH] == '0) begin
                        a_e <= EMIN;
                        a_m <= {1'b0, a[FRACTION_WIDTH-1:0]};
                    end else begin
                        a_e <= $signed({2'b00, a[DATA_WIDTH-2 -: EXPONENT_WIDTH]}) - EW'(BIAS);
                        a_m <= {1'b1, a[FRACTION_WIDTH-1:0]};
                    end
                    if (b[DATA_WIDTH-2 -: EXPONENT_WIDTH] == '0) begin
                        b_e <= EMIN;
                        b_m <= {1'b0, b[FRACTION_WIDTH-1:0]};
                    end else begin
                        b_e <= $signed({2'b00, b[DATA_WIDTH-2 -: EXPONENT_WIDTH]}) - EW'(BIAS);
                        b_m <= {1'b1, b[FRACTION_WIDTH-1:0]};
                    end
                end
                SPECIAL: begin
                    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
                        output_z <= QNAN;
                    else if (a_inf || b_inf)
                        output_z <= {z_s, {EXPONENT_WIDTH{1'b1}}, {FRACTION_WIDTH{1'b0}}};
                    else if (a_zero || b_zero)
                        output_z <= {z_s, {(DATA_WIDTH-1){1'b0}}};
                end
                NORM_IN: begin
                    if (!a_m[MW-1]) begin
                        a_m <= a_m << 1;
                        a_e <= a_e - 1'b1;
                    end
                    if (!b_m[MW-1]) begin
                        b_m <= b_m << 1;
                        b_e <= b_e - 1'b1;
                    end
                end
                MULT: begin
                    p      <= PW'(a_m) * PW'(b_m);
                    z_e    <= a_e + b_e + 1'b1;
                    sticky <= 1'b0;
                end
                NORM_L: begin
                    if (!p[PW-1]) begin
                        p   <= p << 1;
                        z_e <= z_e - 1'b1;
                    end
                end
                NORM_R: begin
                    if (z_e < EMIN) begin
                        p      <= p >> 1;
                        sticky <= sticky | p[0];
                        z_e    <= z_e + 1'b1;
                    end
                end
                ROUND: begin
                    if (round_up) begin
                        if (mant_inc[MW]) begin
                            z_m <= {1'b1, {(MW-1){1'b0}}};
                            z_e <= z_e + 1'b1;
                        end else begin
                            z_m <= mant_inc[MW-1:0];
                        end
                    end else begin
                        z_m <= p[PW-1 -: MW];
                    end
                end
                PACK: begin
                    if (z_e > EMAX)
                        output_z <= {z_s, {EXPONENT_WIDTH{1'b1}}, {FRACTION_WIDTH{1'b0}}};
                    else if ((z_e == EMIN) && !z_m[MW-1])
                        output_z <= {z_s, {EXPONENT_WIDTH{1'b0}}, z_m[FRACTION_WIDTH-1:0]};
                    else
                        output_z <= {z_s, pack_field, z_m[FRACTION_WIDTH-1:0]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_core.sv
// Scoreboard bench for fp_mul_core: directed binary32 vectors with hand-computed products,
// plus latency, backpressure, reset-abort and protocol checks.
module tb_fp_mul_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] input_a = '0, input_b = '0;
    logic        input_a_stb = 1'b0, input_b_stb = 1'b0;
    logic        input_a_ack, input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    logic [31:0] exp_q[$];

    fp_mul_core dut (
        .clk(clk), .rst_n(rst_n),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // monitor: a Z transfer happens on the next rising edge
    always @(negedge clk) begin
        if (rst_n && output_z_stb && output_z_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL z_unexpected: got %08h expected no result", output_z);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (output_z !== e) begin
                    failures++;
                    $display("FAIL z_value: got %08h expected %08h", output_z, e);
                end
            end
            n_done++;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input bit push);
        bit ok;
        if (push) exp_q.push_back(z);
        input_a = a;
        input_a_stb = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (input_a_ack) ok = 1;
        end
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        if (!ok) chk("a_xfer_timeout", 32'd0, 32'd1);
        input_b = b;
        input_b_stb = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (input_b_ack) ok = 1;
        end
        @(posedge clk); #1;
        input_b_stb = 1'b0;
        if (!ok) chk("b_xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int i;
        i = 0;
        while (n_done < target && i < 2000) begin
            @(posedge clk);
            i++;
        end
        if (n_done < target) chk("result_timeout", 32'(n_done), 32'(target));
        @(posedge clk); #1;
    endtask

    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] z; } vec_t;
    vec_t vecs[$];

    initial begin
        int cnt;
        logic [31:0] held;

        vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000});
        vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000});
        vecs.push_back('{32'h7FC12345, 32'h3F800000, 32'h7FC00000});
        vecs.push_back('{32'h7F7FFFFF, 32'h40000000, 32'h7F800000});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002});
        vecs.push_back('{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE});
        vecs.push_back('{32'h40400000, 32'hC0000000, 32'hC0C00000});
        vecs.push_back('{32'h00800000, 32'h3F000000, 32'h00400000});
        vecs.push_back('{32'h80000001, 32'h3F800000, 32'h80000001});
        vecs.push_back('{32'h00000001, 32'h00000001, 32'h00000000});

        #2;
        chk("rst_a_ack", 32'(input_a_ack), 32'd0);
        chk("rst_z_stb", 32'(output_z_stb), 32'd0);
        chk("rst_z", output_z, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_a_ack", 32'(input_a_ack), 32'd1);

        // B strobe alone while waiting for A must not be acknowledged
        input_b = 32'h40000000;
        input_b_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_ack_in_get_a", 32'(input_b_ack), 32'd0);
        end
        @(posedge clk); #1;
        input_b_stb = 1'b0;

        // latency and backpressure on 1.5 x 2.0
        output_z_ack = 1'b0;
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 1);
        cnt = 0;
        while (!output_z_stb && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency_cycles", 32'(cnt), 32'd8);
        held = output_z;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_stb", 32'(output_z_stb), 32'd1);
            chk("hold_z", output_z, held);
            chk("hold_a_ack", 32'(input_a_ack), 32'd0);
            chk("hold_b_ack", 32'(input_b_ack), 32'd0);
        end
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        chk("stb_drop", 32'(output_z_stb), 32'd0);
        chk("a_ack_back", 32'(input_a_ack), 32'd1);
        chk("first_done", 32'(n_done), 32'd1);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].z, 1);
            wait_done(n_done + 1);
        end

        // reset in MULT: aborts with no result
        send(32'h3FC00000, 32'h40000000, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_a_ack", 32'(input_a_ack), 32'd0);
        chk("abort_b_ack", 32'(input_b_ack), 32'd0);
        chk("abort_z_stb", 32'(output_z_stb), 32'd0);
        chk("abort_z", output_z, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_a_ack", 32'(input_a_ack), 32'd1);
        cnt = n_done;
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 1);
        wait_done(cnt + 1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
